// File: rtl/mac_sequencer.sv
// Initiator sequencer for the 16-bit MAC: streams len operand pairs through clear/mul/mac/sat
// instructions and returns the final {protect,result} on a valid/ready port.
module mac_sequencer #(
   parameter int unsigned LAT   = 2,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk_i,
   input  logic             reset_n,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic             sat_en_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   input  logic             op_valid_i,
   output logic             op_ready_o,
   input  logic [15:0]      op_a_i,
   input  logic [15:0]      op_b_i,
   output logic [2:0]       mac_instruction_o,
   output logic [15:0]      mac_multiplier_o,
   output logic [15:0]      mac_multiplicand_o,
   output logic             mac_stall_o,
   input  logic [31:0]      mac_result_i,
   input  logic [7:0]       mac_protect_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [31:0]      res_data_o,
   output logic [7:0]       res_guard_o,
   output logic             res_ovf_o
);

   localparam logic [2:0] OpClear = 3'b000;

   typedef enum logic [2:0] {StIdle, StFirst, StAcc, StSat, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic             mode_q, mode_d;
   logic             sat_en_q, sat_en_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [2:0]       instr_q, instr_d;
   logic [15:0]      mult_q, mult_d;
   logic [15:0]      mcand_q, mcand_d;
   logic             stall_q, stall_d;
   logic [LAT-1:0]   trk_q, trk_d;
   logic             exit_q, exit_d;
   logic [31:0]      data_q, data_d;
   logic [7:0]       guard_q, guard_d;
   logic             mark;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      sat_en_d = sat_en_q;
      cnt_d    = cnt_q;
      instr_d  = instr_q;
      mult_d   = mult_q;
      mcand_d  = mcand_q;
      stall_d  = 1'b0;
      data_d   = data_q;
      guard_d  = guard_q;
      mark     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               mode_d   = mode_i;
               sat_en_d = sat_en_i;
               cnt_d    = len_i;
               instr_d  = OpClear;
               if (len_i == '0) begin
                  // Empty job: the clear itself (or the following sat) carries the result.
                  mark    = !sat_en_i;
                  state_d = sat_en_i ? StSat : StDrain;
               end else begin
                  state_d = StFirst;
               end
            end
         end
         StFirst, StAcc: begin
            if (op_valid_i) begin
               instr_d = {mode_q, (state_q == StFirst) ? 2'b01 : 2'b10};
               mult_d  = op_a_i;
               mcand_d = op_b_i;
               cnt_d   = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  mark    = !sat_en_q;
                  state_d = sat_en_q ? StSat : StDrain;
               end else begin
                  state_d = StAcc;
               end
            end else begin
               stall_d = 1'b1;
            end
         end
         StSat: begin
            instr_d = {mode_q, 2'b11};
            mark    = 1'b1;
            state_d = StDrain;
         end
         StDrain: begin
            instr_d = OpClear;
            if (exit_q) begin
               data_d  = mac_result_i;
               guard_d = mac_protect_i;
               state_d = StDone;
            end
         end
         StDone: begin
            if (res_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Marker advances only when the MAC pipeline advances; exit_q flags the cycle its result is
      // on mac_result_i.
      trk_d    = stall_q ? trk_q : (trk_q << 1);
      trk_d[0] = trk_d[0] | mark;
      exit_d   = !stall_q && trk_q[LAT-1];
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         mode_q   <= 1'b0;
         sat_en_q <= 1'b0;
         cnt_q    <= '0;
         instr_q  <= OpClear;
         mult_q   <= '0;
         mcand_q  <= '0;
         stall_q  <= 1'b0;
         trk_q    <= '0;
         exit_q   <= 1'b0;
         data_q   <= '0;
         guard_q  <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         sat_en_q <= sat_en_d;
         cnt_q    <= cnt_d;
         instr_q  <= instr_d;
         mult_q   <= mult_d;
         mcand_q  <= mcand_d;
         stall_q  <= stall_d;
         trk_q    <= trk_d;
         exit_q   <= exit_d;
         data_q   <= data_d;
         guard_q  <= guard_d;
      end
   end

   always_comb begin
      if (mode_q) begin
         res_ovf_o = (guard_q[3:0] != {4{data_q[15]}}) || (guard_q[7:4] != {4{data_q[31]}});
      end else begin
         res_ovf_o = guard_q != {8{data_q[31]}};
      end
   end

   assign busy_o             = state_q != StIdle;
   assign op_ready_o         = (state_q == StFirst) || (state_q == StAcc);
   assign res_valid_o        = state_q == StDone;
   assign res_data_o         = data_q;
   assign res_guard_o        = guard_q;
   assign mac_instruction_o  = instr_q;
   assign mac_multiplier_o   = mult_q;
   assign mac_multiplicand_o = mcand_q;
   assign mac_stall_o        = stall_q;

endmodule
